// File: rtl/stall_pkg.sv
// rtl/stall_pkg.sv - shared types and helpers for the fetch/writeback stall sequencer
//
// Purpose: sequencer state encoding (also reused by core perf counters) and
// the latency clamp helper.
package stall_pkg;

  // Encoding 2'b11 is never entered by design; the sequencer recovers from it.
  typedef enum logic [1:0] {
    ST_ISSUE  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2
  } stall_state_t;

  localparam int ST_W = 2;

  // Saturate a requested latency to the largest latency the counter supports.
  function automatic int unsigned clamp_lat(input int unsigned lat,
                                            input int unsigned lat_max);
    return (lat > lat_max) ? lat_max : lat;
  endfunction

endpackage

// File: rtl/lat_down_counter.sv
// rtl/lat_down_counter.sv - loadable down counter timing the memory read latency
//
// Purpose: holds the remaining WAIT cycles of the current instruction.
// Ports:
//   clk          in   clock, rising edge
//   i_resetn     in   synchronous active-low reset, clears the count
//   i_clear      in   clears the count (beats freeze/load/dec)
//   i_freeze     in   holds the count (beats load/dec)
//   i_load       in   loads i_load_val
//   i_load_val   in   value to load
//   i_dec        in   decrements by one, saturating at zero
//   o_count      out  current count
//   o_is_one     out  count equals one (last WAIT cycle)
module lat_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             i_resetn,
  input  logic             i_clear,
  input  logic             i_freeze,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (!i_freeze) begin
      if (i_load) begin
        r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
        // Guarded so a stray decrement can never wrap to all-ones.
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_count  = r_count;
  assign o_is_one = (r_count == CNT_W'(1));

endmodule

// File: rtl/stall_seq.sv
// rtl/stall_seq.sv - fetch/writeback stall sequencer with programmable read latency
//
// Purpose: steps ISSUE -> WAIT (lat_eff cycles) -> COMMIT per instruction,
// producing the PC advance, memory stall window and register write enable.
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-low reset
//   lat_cfg       in   memory read latency, sampled in ISSUE, clamped to LAT_MAX
//   hold          in   freezes state and counter
//   flush         in   restarts at ISSUE, squashes a pending write
//   pc_advance    out  select next PC
//   mem_stall     out  memory read in flight
//   reg_write_en  out  register file write permitted
//   state         out  current state (debug/perf)
//   wait_left     out  remaining WAIT cycles including the current one
module stall_seq
  import stall_pkg::*;
#(
  parameter int LAT_MAX = 4,
  parameter int CNT_W   = $clog2(LAT_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] lat_cfg,
  input  logic             hold,
  input  logic             flush,
  output logic             pc_advance,
  output logic             mem_stall,
  output logic             reg_write_en,
  output logic [ST_W-1:0]  state,
  output logic [CNT_W-1:0] wait_left
);

  stall_state_t     r_state;
  logic [CNT_W-1:0] w_lat_eff;
  logic [CNT_W-1:0] w_count;
  logic             w_is_one;
  logic             w_illegal;
  logic             w_is_issue;
  logic             w_is_wait;
  logic             w_is_commit;

  assign w_lat_eff   = CNT_W'(clamp_lat(32'(lat_cfg), 32'(LAT_MAX)));
  assign w_is_issue  = (r_state == ST_ISSUE);
  assign w_is_wait   = (r_state == ST_WAIT);
  assign w_is_commit = (r_state == ST_COMMIT);
  assign w_illegal   = !(w_is_issue || w_is_wait || w_is_commit);

  // Counter controls mirror the FSM priority: flush/illegal clear beats hold,
  // hold beats the load in ISSUE and the decrement in WAIT.
  lat_down_counter #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .i_resetn   (reset),
    .i_clear    (flush || w_illegal),
    .i_freeze   (hold),
    .i_load     (w_is_issue),
    .i_load_val (w_lat_eff),
    .i_dec      (w_is_wait),
    .o_count    (w_count),
    .o_is_one   (w_is_one)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_ISSUE;
    end else if (flush || w_illegal) begin
      // Illegal encodings recover even under hold so they cannot stick.
      r_state <= ST_ISSUE;
    end else if (!hold) begin
      case (r_state)
        ST_ISSUE:  r_state <= (w_lat_eff != '0) ? ST_WAIT : ST_COMMIT;
        // Leaving at count one keeps the counter from ever underflowing.
        ST_WAIT:   if (w_is_one) r_state <= ST_COMMIT;
        ST_COMMIT: r_state <= ST_ISSUE;
        default:   r_state <= ST_ISSUE;
      endcase
    end
  end

  // Outputs decode the state register directly; reset forces them low so
  // downstream never sees a stale state while the core is held in reset.
  assign pc_advance   = reset && w_is_issue && !hold;
  assign mem_stall    = reset && w_is_wait;
  assign reg_write_en = reset && w_is_commit && !hold && !flush;
  assign state        = (reset && !w_illegal) ? ST_W'(r_state) : '0;
  assign wait_left    = (reset && w_is_wait) ? w_count : '0;

endmodule

// File: doc/stall_seq.md
# stall_seq

Parametrised fetch/writeback stall sequencer for the single-issue core. It generalises the fixed six-cycle stall ring to a run-time-programmable memory read latency. It adds a pipeline hold input and a branch flush input. It sits between the BRAM instruction/data memories and the PC mux and register-file write port, and emits one PC advance, a memory-stall window and one register-write enable per instruction.

## Interface
- `LAT_MAX`, default 4: largest supported memory read latency in cycles; must be ≥1.
- `CNT_W`, default `$clog2(LAT_MAX+1)`: width of the latency config and counter.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `lat_cfg`  in  CNT_W  memory read latency in cycles; 0 is legal.
- `hold`  in  1  external stall (multi-cycle op, bus busy); freezes the sequence.
- `flush`  in  1  branch/jump redirect; restarts the sequence and squashes the pending write.
- `pc_advance`  out  1  PC mux selects next PC (1) or current PC (0).
- `mem_stall`  out  1  memory read in flight; downstream stages stall.
- `reg_write_en`  out  1  register file write permitted this cycle.
- `state`  out  2  current sequencer state, for debug/perf.
- `wait_left`  out  CNT_W  remaining WAIT cycles, including the current one; 0 outside WAIT.

## Operation
- States:
  - ISSUE=0: fetch issued, PC advances.
  - WAIT=1: read latency elapses.
  - COMMIT=2: writeback.
  - Encoding 3 is illegal and recovers to ISSUE on the next edge.
- Latency capture: in ISSUE, `lat_eff = min(lat_cfg, LAT_MAX)` is sampled into the counter. `lat_cfg` changes at other times take effect only at the next ISSUE.
- Transitions, with hold=0 and flush=0:
  - ISSUE→WAIT if lat_eff≠0, else ISSUE→COMMIT.
  - WAIT: the counter decrements each cycle; WAIT→COMMIT on the cycle where the counter equals 1.
  - COMMIT→ISSUE.
- Sequence period is lat_eff+2 cycles.
- Outputs (combinational from the state register plus `hold`):
  - `pc_advance` = (state==ISSUE) & ~hold.
  - `mem_stall` = (state==WAIT).
  - `reg_write_en` = (state==COMMIT) & ~hold & ~flush.
  - All outputs are forced 0 while `reset`=0.
- hold=1: state and counter are frozen. `pc_advance` and `reg_write_en` are 0. `mem_stall` keeps its state value.
- flush=1: the next state is ISSUE from any state and the counter is cleared. `reg_write_en` is 0 in the flush cycle.
- Priority: reset > flush > hold > normal sequencing.
- Counter width is CNT_W. It never underflows, because the WAIT exit is taken at count 1.

## Timing
- Reset: while `reset`=0 at an edge, state←ISSUE and counter←0. All outputs read 0 during reset.
- First edge with `reset`=1 is cycle 0. `pc_advance`=1 in cycle 0 unless hold=1.
- Fetch-to-writeback: `reg_write_en` rises lat_eff+1 cycles after `pc_advance`, with no hold.
- `mem_stall` is high for exactly lat_eff consecutive cycles per instruction, plus any hold cycles that land in WAIT.
- A hold of H cycles in any state stretches the period by exactly H.
- Flush:
  - Flush in cycle t gives ISSUE in t+1.
  - If the flush cycle was COMMIT, its write is squashed.
  - Flush during ISSUE re-issues in t+1.
- Simultaneous hold and flush: flush wins.
- Illegal state is detected on the next edge and goes to ISSUE; outputs read 0 in the illegal cycle.
- No pipelined outputs; there is zero extra latency from the state register.

## Structure
- `stall_pkg` holds:
  - the `stall_state_t` enum (ST_ISSUE, ST_WAIT, ST_COMMIT);
  - the `clamp_lat` function.
- The processor top reuses `stall_state_t` for perf counters.
- One sub-module, `lat_down_counter`:
  - parametrised by CNT_W;
  - load, decrement, clear and freeze controls;
  - `is_one` flag output.
- The FSM and output gating live in `stall_seq`.

## Test plan
- Reset and latency 4: hold `reset`=0 for 3 cycles, release with lat_cfg=4 → all outputs 0 during reset. `pc_advance` in cycles 0, 6, 12. `mem_stall` in cycles 1–4. `reg_write_en` in cycles 5, 11.
- Zero latency: lat_cfg=0 → period 2. `pc_advance` and `reg_write_en` alternate. `mem_stall` never asserts.
- Hold: lat_cfg=2, hold=1 for 3 cycles entering WAIT and for 1 cycle in COMMIT → `mem_stall` high 5 cycles. `reg_write_en` is delayed 1 cycle and pulses once. Period becomes 8.
- Flush:
  - lat_cfg=3, flush in the 2nd WAIT cycle → ISSUE next cycle. No `reg_write_en` for the aborted instruction. `wait_left`=0.
  - Flush with hold in COMMIT → write squashed, ISSUE next cycle.
- Clamp and sampling:
  - LAT_MAX=4 with lat_cfg=7 → 4 WAIT cycles.
  - Change lat_cfg from 1 to 3 mid-WAIT → the current instruction keeps 1 WAIT cycle; the next instruction gets 3.
- Mid-operation reset: assert `reset`=0 during WAIT → outputs 0 immediately. State is ISSUE on release.
